// File: rtl/rc4_xor_stream.sv
// -----------------------------------------------------------------------------
// rc4_xor_stream
//   Consumes RC4 keystream bytes into a small FIFO and XORs each one with a
//   plaintext byte to produce ciphertext (or plaintext, since RC4 is symmetric).
//   Each message is exactly msg_len bytes long. Completion is flagged by a
//   one-cycle done pulse after the last ciphertext byte has been taken.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   clear                 : synchronous flush (FIFO, output register, FSM)
//   ks_valid/ks_data/ks_ready : keystream input handshake (ks_ready = !full)
//   start, msg_len        : message kick-off, length latched on accepted start
//   pt_valid/pt_data/pt_ready : plaintext input handshake
//   ct_valid/ct_data/ct_ready : ciphertext output register handshake
//   busy                  : message in progress (RUN or DRAIN)
//   done                  : one-cycle completion pulse
//   byte_cnt              : plaintext bytes accepted in current/last message
// -----------------------------------------------------------------------------
module rc4_xor_stream #(
   parameter int unsigned KS_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        ks_valid,
   input  logic [7:0]  ks_data,
   output logic        ks_ready,
   input  logic        start,
   input  logic [15:0] msg_len,
   input  logic        pt_valid,
   input  logic [7:0]  pt_data,
   output logic        pt_ready,
   output logic        ct_valid,
   input  logic        ct_ready,
   output logic [7:0]  ct_data,
   output logic        busy,
   output logic        done,
   output logic [15:0] byte_cnt
);

   localparam int unsigned AW = (KS_DEPTH > 2) ? $clog2(KS_DEPTH) : 1;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(KS_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Keystream FIFO state
   logic [7:0]    mem_q [KS_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q,  count_d;

   // Control state
   state_t        state_q;
   logic [15:0]   rem_q;
   logic [15:0]   byte_cnt_q;
   logic          ct_valid_q;
   logic [7:0]    ct_data_q;
   logic          busy_q;
   logic          done_q;

   logic          full_s;
   logic          empty_s;
   logic          push_s;
   logic          fire_s;
   logic          ct_hs_s;
   logic [7:0]    head_s;

   assign full_s   = (count_q == FULL_CNT);
   assign empty_s  = (count_q == '0);
   assign head_s   = mem_q[rd_ptr_q];

   // ks_ready depends only on registered occupancy, never on a same-cycle pop.
   assign ks_ready = ~full_s;
   assign push_s   = ks_valid & ~full_s;

   // A new byte may enter the output register only if it is empty or being drained.
   assign pt_ready = (state_q == ST_RUN) & ~empty_s & (rem_q != 16'd0) &
                     (~ct_valid_q | ct_ready);
   assign fire_s   = pt_valid & pt_ready;
   assign ct_hs_s  = ct_valid_q & ct_ready;

   assign ct_valid = ct_valid_q;
   assign ct_data  = ct_data_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign byte_cnt = byte_cnt_q;

   // FIFO pointer/occupancy next-state; clear empties the FIFO.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (fire_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, fire_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // FIFO pointer/occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage; a write during clear is dropped since the pointers reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(KS_DEPTH); i++) begin
            mem_q[i] <= 8'h00;
         end
      end else if (push_s && !clear) begin
         mem_q[wr_ptr_q] <= ks_data;
      end
   end

   // Message FSM with output register, counters and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rem_q      <= 16'd0;
         byte_cnt_q <= 16'd0;
         ct_valid_q <= 1'b0;
         ct_data_q  <= 8'h00;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else if (clear) begin
         // Abort: byte_cnt keeps its value so software can see how far it got.
         state_q    <= ST_IDLE;
         rem_q      <= 16'd0;
         ct_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;

         if (fire_s) begin
            ct_data_q  <= pt_data ^ head_s;
            ct_valid_q <= 1'b1;
         end else if (ct_hs_s) begin
            ct_valid_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  byte_cnt_q <= 16'd0;
                  if (msg_len != 16'd0) begin
                     state_q <= ST_RUN;
                     rem_q   <= msg_len;
                     busy_q  <= 1'b1;
                  end else begin
                     // Empty message completes immediately without going busy.
                     done_q  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (fire_s) begin
                  rem_q      <= rem_q - 16'd1;
                  byte_cnt_q <= byte_cnt_q + 16'd1;
                  if (rem_q == 16'd1) begin
                     state_q <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               // Last byte is sitting in the output register; finish on its handshake.
               if (ct_hs_s) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rc4_xor_stream.sv
// -----------------------------------------------------------------------------
// tb_rc4_xor_stream
//   Directed self-checking bench for rc4_xor_stream: a table of single-byte
//   messages followed by hand-written multi-cycle sequences (streaming,
//   continuity, FIFO boundaries, back-pressure, clear and async reset).
// -----------------------------------------------------------------------------
module tb_rc4_xor_stream;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        ks_valid;
   logic [7:0]  ks_data;
   logic        ks_ready;
   logic        start;
   logic [15:0] msg_len;
   logic        pt_valid;
   logic [7:0]  pt_data;
   logic        pt_ready;
   logic        ct_valid;
   logic        ct_ready;
   logic [7:0]  ct_data;
   logic        busy;
   logic        done;
   logic [15:0] byte_cnt;

   int checks;
   int errors;

   typedef struct packed {
      logic [7:0] ks;
      logic [7:0] pt;
      logic [7:0] ct;
   } vec_t;

   vec_t vecs [6];

   rc4_xor_stream #(.KS_DEPTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .ks_valid (ks_valid),
      .ks_data  (ks_data),
      .ks_ready (ks_ready),
      .start    (start),
      .msg_len  (msg_len),
      .pt_valid (pt_valid),
      .pt_data  (pt_data),
      .pt_ready (pt_ready),
      .ct_valid (ct_valid),
      .ct_ready (ct_ready),
      .ct_data  (ct_data),
      .busy     (busy),
      .done     (done),
      .byte_cnt (byte_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic push_ks(input logic [7:0] b);
      ks_valid = 1'b1;
      ks_data  = b;
      step();
      ks_valid = 1'b0;
   endtask

   task automatic start_msg(input logic [15:0] len);
      start   = 1'b1;
      msg_len = len;
      step();
      start   = 1'b0;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      clear    = 1'b0;
      ks_valid = 1'b0;
      ks_data  = 8'h00;
      start    = 1'b0;
      msg_len  = 16'd0;
      pt_valid = 1'b0;
      pt_data  = 8'h00;
      ct_ready = 1'b1;

      vecs[0] = '{ks: 8'hA5, pt: 8'h3C, ct: 8'h99};
      vecs[1] = '{ks: 8'hFF, pt: 8'hFF, ct: 8'h00};
      vecs[2] = '{ks: 8'h00, pt: 8'h5A, ct: 8'h5A};
      vecs[3] = '{ks: 8'h0F, pt: 8'hF0, ct: 8'hFF};
      vecs[4] = '{ks: 8'h12, pt: 8'h34, ct: 8'h26};
      vecs[5] = '{ks: 8'h80, pt: 8'h01, ct: 8'h81};

      // ---------------- reset state ----------------
      #12;
      rst_n = 1'b1;
      step();
      chkb ("rst_ks_ready", ks_ready, 1'b1);
      chkb ("rst_pt_ready", pt_ready, 1'b0);
      chkb ("rst_ct_valid", ct_valid, 1'b0);
      chk8 ("rst_ct_data",  ct_data,  8'h00);
      chkb ("rst_busy",     busy,     1'b0);
      chkb ("rst_done",     done,     1'b0);
      chk16("rst_byte_cnt", byte_cnt, 16'd0);

      // ---------------- table: single-byte messages ----------------
      for (int v = 0; v < 6; v++) begin
         push_ks(vecs[v].ks);
         start_msg(16'd1);
         pt_valid = 1'b1;
         pt_data  = vecs[v].pt;
         #1;
         chkb("tbl_pt_ready", pt_ready, 1'b1);
         step();
         pt_valid = 1'b0;
         chkb ("tbl_ct_valid", ct_valid, 1'b1);
         chk8 ("tbl_ct_data",  ct_data,  vecs[v].ct);
         chkb ("tbl_busy",     busy,     1'b1);
         chkb ("tbl_no_early_done", done, 1'b0);
         step();
         chkb ("tbl_done",     done,     1'b1);
         chkb ("tbl_busy_low", busy,     1'b0);
         chkb ("tbl_ct_clr",   ct_valid, 1'b0);
         chk16("tbl_byte_cnt", byte_cnt, 16'd1);
         step();
         chkb ("tbl_done_pulse", done, 1'b0);
      end

      // ---------------- streaming 8 bytes ----------------
      begin
         logic [7:0] got [$];
         int         got_cyc [$];
         int         done_cnt;
         done_cnt = 0;
         start_msg(16'd8);
         pt_valid = 1'b1;
         pt_data  = 8'hFF;
         fork
            begin
               for (int i = 1; i <= 8; i++) begin
                  logic acc;
                  acc      = 1'b0;
                  ks_valid = 1'b1;
                  ks_data  = 8'(i);
                  for (int t = 0; t < 50 && !acc; t++) begin
                     acc = ks_ready;
                     step();
                  end
               end
               ks_valid = 1'b0;
            end
            begin
               for (int c = 0; c < 20; c++) begin
                  step();
                  if (ct_valid && ct_ready) begin
                     got.push_back(ct_data);
                     got_cyc.push_back(c);
                  end
                  if (done) done_cnt++;
               end
            end
         join
         pt_valid = 1'b0;
         chk16("strm_count", 16'(got.size()), 16'd8);
         for (int i = 0; i < got.size() && i < 8; i++) begin
            chk8("strm_ct", got[i], 8'hFF ^ 8'(i + 1));
         end
         if (got.size() == 8) begin
            chk16("strm_consecutive", 16'(got_cyc[7] - got_cyc[0]), 16'd7);
         end
         chk16("strm_done_once", 16'(done_cnt), 16'd1);
         chk16("strm_byte_cnt",  byte_cnt, 16'd8);
      end

      // ---------------- continuity + push/pop at occupancy 2 ----------------
      push_ks(8'hA1);
      push_ks(8'hB2);
      push_ks(8'hC3);
      push_ks(8'hD4);
      chkb("cont_full", ks_ready, 1'b0);
      start_msg(16'd2);
      pt_valid = 1'b1;
      pt_data  = 8'h00;
      step();
      chk8("contA_b1", ct_data, 8'hA1);
      step();
      chk8("contA_b2", ct_data, 8'hB2);
      pt_valid = 1'b0;
      step();
      chkb("contA_done", done, 1'b1);
      start_msg(16'd2);
      pt_valid = 1'b1;
      ks_valid = 1'b1;
      ks_data  = 8'hE5;
      step();
      ks_valid = 1'b0;
      pt_valid = 1'b0;
      chk8("contB_b1", ct_data, 8'hC3);
      step();
      chkb("pp_occ2_ready", ks_ready, 1'b1);
      push_ks(8'hF6);
      chkb("pp_occ3_ready", ks_ready, 1'b1);
      push_ks(8'h07);
      chkb("pp_occ4_full", ks_ready, 1'b0);
      pt_valid = 1'b1;
      step();
      pt_valid = 1'b0;
      chk8("contB_b2", ct_data, 8'hD4);
      step();
      chkb ("contB_done", done, 1'b1);
      chk16("contB_cnt",  byte_cnt, 16'd2);
      start_msg(16'd3);
      pt_valid = 1'b1;
      step();
      chk8("drain_b1", ct_data, 8'hE5);
      step();
      chk8("drain_b2", ct_data, 8'hF6);
      step();
      chk8("drain_b3", ct_data, 8'h07);
      pt_valid = 1'b0;
      step();
      chkb("drain_done", done, 1'b1);

      // ---------------- msg_len = 0 ----------------
      start = 1'b1;
      msg_len = 16'd0;
      step();
      start = 1'b0;
      chkb ("zero_done", done, 1'b1);
      chkb ("zero_busy", busy, 1'b0);
      chk16("zero_cnt",  byte_cnt, 16'd0);
      step();
      chkb("zero_done_pulse", done, 1'b0);
      chkb("zero_busy2",      busy, 1'b0);

      // ---------------- FIFO full + back-pressure ----------------
      push_ks(8'h10);
      push_ks(8'h20);
      push_ks(8'h30);
      push_ks(8'h40);
      chkb("full_ks_ready", ks_ready, 1'b0);
      push_ks(8'hEE);
      start_msg(16'd4);
      pt_valid = 1'b1;
      pt_data  = 8'h01;
      step();
      chk8("bp_b1", ct_data, 8'h11);
      chkb("full_rise_after_pop", ks_ready, 1'b1);
      pt_data  = 8'h02;
      ct_ready = 1'b0;
      #1;
      chkb("bp_pt_ready0", pt_ready, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk8("bp_hold_data",  ct_data,  8'h11);
         chkb("bp_hold_valid", ct_valid, 1'b1);
         chkb("bp_pt_ready_k", pt_ready, 1'b0);
      end
      ct_ready = 1'b1;
      #1;
      chkb("bp_pt_ready1", pt_ready, 1'b1);
      step();
      chk8("bp_b2", ct_data, 8'h22);
      pt_data = 8'h03;
      step();
      chk8("bp_b3", ct_data, 8'h33);
      pt_data = 8'h04;
      step();
      chk8("bp_b4", ct_data, 8'h44);
      pt_valid = 1'b0;
      step();
      chkb ("bp_done", done, 1'b1);
      chk16("bp_cnt",  byte_cnt, 16'd4);

      // ---------------- empty FIFO (0xEE must have been refused) ----------------
      start_msg(16'd1);
      pt_valid = 1'b1;
      pt_data  = 8'h00;
      #1;
      chkb("empty_pt_ready", pt_ready, 1'b0);

      // ---------------- clear mid-message ----------------
      ks_valid = 1'b1;
      ks_data  = 8'h55;
      step();
      ks_data  = 8'h66;
      step();
      ks_valid = 1'b0;
      pt_valid = 1'b0;
      ct_ready = 1'b0;
      chk8("clr_pre_ct", ct_data, 8'h55);
      step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      chkb ("clr_ct_valid", ct_valid, 1'b0);
      chkb ("clr_busy",     busy,     1'b0);
      chkb ("clr_done",     done,     1'b0);
      chkb ("clr_pt_ready", pt_ready, 1'b0);
      chk16("clr_cnt_hold", byte_cnt, 16'd1);
      step();
      chkb("clr_done2", done, 1'b0);
      ct_ready = 1'b1;
      start_msg(16'd1);
      pt_valid = 1'b1;
      pt_data  = 8'hF0;
      #1;
      chkb("clr_fifo_empty", pt_ready, 1'b0);
      push_ks(8'h0F);
      #1;
      chkb("clr_pt_ready2", pt_ready, 1'b1);
      step();
      pt_valid = 1'b0;
      chk8("clr_after_ct", ct_data, 8'hFF);
      step();
      chkb("clr_after_done", done, 1'b1);

      // ---------------- async reset mid-message ----------------
      push_ks(8'h3C);
      start_msg(16'd2);
      pt_valid = 1'b1;
      pt_data  = 8'h00;
      step();
      pt_valid = 1'b0;
      chk8("ar_pre_ct", ct_data, 8'h3C);
      #2;
      rst_n = 1'b0;
      #1;
      chkb ("ar_ct_valid", ct_valid, 1'b0);
      chk8 ("ar_ct_data",  ct_data,  8'h00);
      chkb ("ar_busy",     busy,     1'b0);
      chkb ("ar_done",     done,     1'b0);
      chkb ("ar_pt_ready", pt_ready, 1'b0);
      chk16("ar_cnt",      byte_cnt, 16'd0);
      step();
      rst_n = 1'b1;
      step();
      chkb("ar_ks_ready", ks_ready, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
